// File: rtl/serial_adder_pkg.sv
// Shared types for the chunked serial adder/subtractor.
// Imported by the top level for its FSM state encoding.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } sa_state_t;

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple adder built from full_adder cells.
// Exposes the carry into the top cell for signed overflow.
module chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             c_in,
   output logic [CHUNK-1:0] sum,
   output logic             c_out,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = c_in;

   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      full_adder u_fa (
         .a     (a[gi]),
         .b     (b[gi]),
         .c_in  (c[gi]),
         .sum   (sum[gi]),
         .c_out (c[gi+1])
      );
   end

   assign c_out = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Building block of the chunk ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor, CHUNK bits per clock.
// Operands shift right through the chunk adder; results fill from the MSB end.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int N_CYC = WIDTH / CHUNK;
   localparam int CW    = (N_CYC > 1) ? $clog2(N_CYC) : 1;

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a multiple of CHUNK");
   end

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             cy_q, cy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;

   logic [CHUNK-1:0] ch_sum;
   logic             ch_co;
   logic             ch_msb;
   logic [WIDTH-1:0] r_nxt;
   logic             last;

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_q[CHUNK-1:0]),
      .b     (b_q[CHUNK-1:0]),
      .c_in  (cy_q),
      .sum   (ch_sum),
      .c_out (ch_co),
      .c_msb (ch_msb)
   );

   // New chunk enters at the MSB end; oldest bits drop off the bottom.
   assign r_nxt = WIDTH'({ch_sum, r_q} >> CHUNK);
   assign last  = (cnt_q == CW'(N_CYC - 1));

   // Next-state and datapath loads for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               cy_d    = op_sub ? 1'b1 : c_in;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            a_d   = a_q >> CHUNK;
            b_d   = b_q >> CHUNK;
            r_d   = r_nxt;
            cy_d  = ch_co;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               sum_d   = r_nxt;
               co_d    = ch_co;
               ov_d    = ch_msb ^ ch_co;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
      end
   end

   assign ready    = (state_q == IDLE);
   assign valid    = (state_q == DONE);
   assign sum      = sum_q;
   assign c_out    = co_q;
   assign overflow = ov_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised bench for serial_adder over four WIDTH/CHUNK configurations.
// Reference results come from plain integer arithmetic on the operands.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int wid[4]  = '{8, 8, 8, 32};
   int ncyc[4] = '{2, 1, 8, 4};

   logic [3:0]  start_v = '0;
   logic [3:0]  op_v    = '0;
   logic [3:0]  cin_v   = '0;
   logic [31:0] a_v[4]  = '{default: '0};
   logic [31:0] b_v[4]  = '{default: '0};
   logic [3:0]  rdy_v, vld_v, co_v, ov_v;
   logic [31:0] sum_v[4];
   logic [7:0]  s0, s1, s2;
   logic [31:0] s3;
   logic [31:0] prev_sum[4] = '{default: '0};
   logic        prev_co[4]  = '{default: 1'b0};
   logic        prev_ov[4]  = '{default: 1'b0};

   int n_cmp = 0;
   int n_err = 0;

   assign sum_v[0] = {24'd0, s0};
   assign sum_v[1] = {24'd0, s1};
   assign sum_v[2] = {24'd0, s2};
   assign sum_v[3] = s3;

   serial_adder #(.WIDTH(8), .CHUNK(4)) u_d0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .op_sub(op_v[0]),
      .a(a_v[0][7:0]), .b(b_v[0][7:0]), .c_in(cin_v[0]),
      .ready(rdy_v[0]), .valid(vld_v[0]), .sum(s0),
      .c_out(co_v[0]), .overflow(ov_v[0]));

   serial_adder #(.WIDTH(8), .CHUNK(8)) u_d1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .op_sub(op_v[1]),
      .a(a_v[1][7:0]), .b(b_v[1][7:0]), .c_in(cin_v[1]),
      .ready(rdy_v[1]), .valid(vld_v[1]), .sum(s1),
      .c_out(co_v[1]), .overflow(ov_v[1]));

   serial_adder #(.WIDTH(8), .CHUNK(1)) u_d2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .op_sub(op_v[2]),
      .a(a_v[2][7:0]), .b(b_v[2][7:0]), .c_in(cin_v[2]),
      .ready(rdy_v[2]), .valid(vld_v[2]), .sum(s2),
      .c_out(co_v[2]), .overflow(ov_v[2]));

   serial_adder #(.WIDTH(32), .CHUNK(8)) u_d3 (
      .clk(clk), .rst(rst), .start(start_v[3]), .op_sub(op_v[3]),
      .a(a_v[3]), .b(b_v[3]), .c_in(cin_v[3]),
      .ready(rdy_v[3]), .valid(vld_v[3]), .sum(s3),
      .c_out(co_v[3]), .overflow(ov_v[3]));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask_of(input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      return m[31:0];
   endfunction

   function automatic longint sx(input longint v, input int w);
      longint half;
      half = longint'(1) << (w - 1);
      return (v >= half) ? v - (half << 1) : v;
   endfunction

   // Unsigned result modulo 2^w, carry as bit w (no-borrow for sub),
   // overflow when the true signed result leaves the w-bit range.
   function automatic void ref_model(input int w, input bit sub,
                                     input logic [31:0] av,
                                     input logic [31:0] bv, input bit ci,
                                     output logic [31:0] s,
                                     output bit co, output bit ov);
      longint ua, ub, full, sr, lim;
      ua = longint'(av);
      ub = longint'(bv);
      lim = longint'(1) << (w - 1);
      if (sub) begin
         full = ua - ub;
         co   = (ua >= ub);
         sr   = sx(ua, w) - sx(ub, w);
      end else begin
         full = ua + ub + longint'(ci);
         co   = ((full >> w) & 1) != 0;
         sr   = sx(ua, w) + sx(ub, w) + longint'(ci);
      end
      s  = 32'(full & ((longint'(1) << w) - 1));
      ov = (sr < -lim) || (sr > lim - 1);
   endfunction

   task automatic run_op(input int i, input bit sub, input logic [31:0] av,
                         input logic [31:0] bv, input bit ci,
                         input logic [31:0] es, input bit eco,
                         input bit eov);
      int lat;
      logic [31:0] m;
      m = mask_of(wid[i]);
      lat = 0;
      while (!rdy_v[i] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("idle_wait", 64'(rdy_v[i]), 64'd1);
      start_v[i] = 1'b1;
      op_v[i]    = sub;
      a_v[i]     = av & m;
      b_v[i]     = bv & m;
      cin_v[i]   = ci;
      @(negedge clk);
      start_v[i] = 1'b0;
      a_v[i]     = $urandom & m;
      b_v[i]     = $urandom & m;
      op_v[i]    = 1'($urandom);
      cin_v[i]   = 1'($urandom);
      lat = 0;
      while (!vld_v[i] && lat < 200) begin
         check("busy_rdy", 64'(rdy_v[i]), 64'd0);
         check("hold_sum", 64'(sum_v[i]), 64'(prev_sum[i]));
         check("hold_co", 64'(co_v[i]), 64'(prev_co[i]));
         check("hold_ov", 64'(ov_v[i]), 64'(prev_ov[i]));
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(ncyc[i]));
      check("sum", 64'(sum_v[i]), 64'(es));
      check("c_out", 64'(co_v[i]), 64'(eco));
      check("overflow", 64'(ov_v[i]), 64'(eov));
      check("done_rdy", 64'(rdy_v[i]), 64'd0);
      prev_sum[i] = es;
      prev_co[i]  = eco;
      prev_ov[i]  = eov;
      @(negedge clk);
      check("pulse_len", 64'(vld_v[i]), 64'd0);
      check("rdy_back", 64'(rdy_v[i]), 64'd1);
   endtask

   initial begin
      logic [31:0] ra, rb, es;
      bit rs, rc, eco, eov;
      int lat;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("rst_ready", 64'(rdy_v[i]), 64'd1);
         check("rst_valid", 64'(vld_v[i]), 64'd0);
         check("rst_sum", 64'(sum_v[i]), 64'd0);
         check("rst_cout", 64'(co_v[i]), 64'd0);
         check("rst_ovf", 64'(ov_v[i]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      run_op(0, 1'b0, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0);
      run_op(0, 1'b0, 32'hFF, 32'h01, 1'b1, 32'h01, 1'b1, 1'b0);
      run_op(0, 1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1);
      run_op(0, 1'b1, 32'h05, 32'h07, 1'b0, 32'hFE, 1'b0, 1'b0);
      run_op(0, 1'b1, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b1);

      start_v[0] = 1'b1;
      op_v[0] = 1'b0;
      a_v[0] = 32'h0F;
      b_v[0] = 32'h01;
      cin_v[0] = 1'b0;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("pre_rst_busy", 64'(rdy_v[0]), 64'd0);
      rst = 1'b1;
      #1;
      check("abort_ready", 64'(rdy_v[0]), 64'd1);
      check("abort_valid", 64'(vld_v[0]), 64'd0);
      check("abort_sum", 64'(sum_v[0]), 64'd0);
      check("abort_cout", 64'(co_v[0]), 64'd0);
      check("abort_ovf", 64'(ov_v[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         prev_sum[i] = '0;
         prev_co[i]  = 1'b0;
         prev_ov[i]  = 1'b0;
      end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("no_late_valid", 64'(vld_v[0]), 64'd0);
      end
      run_op(0, 1'b0, 32'h12, 32'h34, 1'b1, 32'h47, 1'b0, 1'b0);

      start_v[0] = 1'b1;
      op_v[0] = 1'b0;
      cin_v[0] = 1'b0;
      a_v[0] = 32'h0F;
      b_v[0] = 32'h01;
      for (int j = 1; j <= ncyc[0] + 1; j++) begin
         @(negedge clk);
         a_v[0] = $urandom & 32'hFF;
         b_v[0] = $urandom & 32'hFF;
         check("hs_rdy_low", 64'(rdy_v[0]), 64'd0);
         check("hs_valid", 64'(vld_v[0]), 64'(j == ncyc[0] + 1));
      end
      check("hs_sum", 64'(sum_v[0]), 64'h10);
      a_v[0] = 32'h20;
      b_v[0] = 32'h03;
      @(negedge clk);
      check("hs_idle", 64'(rdy_v[0]), 64'd1);
      check("hs_no_dup", 64'(vld_v[0]), 64'd0);
      @(negedge clk);
      start_v[0] = 1'b0;
      check("hs_accept2", 64'(rdy_v[0]), 64'd0);
      lat = 0;
      while (!vld_v[0] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("hs_latency2", 64'(lat), 64'(ncyc[0]));
      check("hs_sum2", 64'(sum_v[0]), 64'h23);
      prev_sum[0] = 32'h23;
      prev_co[0]  = 1'b0;
      prev_ov[0]  = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         for (int n = 0; n < 1000; n++) begin
            ra = $urandom & mask_of(wid[i]);
            rb = $urandom & mask_of(wid[i]);
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (n % 16 == 0) ra = mask_of(wid[i]);
            if (n % 16 == 1) rb = '0;
            ref_model(wid[i], rs, ra, rb, rs ? 1'b0 : rc, es, eco, eov);
            run_op(i, rs, ra, rb, rc, es, eco, eov);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, carrying between chunks in a register. It is the sequential successor to the combinational `full_adder`: the chunk datapath is a ripple chain of `full_adder` cells, wrapped in a start/ready/valid FSM. It adds subtraction and signed-overflow detection, and trades latency for a short critical path in wide datapaths.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of CHUNK (elaboration-time error otherwise)
- `CHUNK`, 8, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH
- derived `N_CYC = WIDTH/CHUNK`, `CW = $clog2(N_CYC)` (min 1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; accepted only when `ready`=1
- `op_sub`  in  1  0: a+b+c_in; 1: a−b (a + ~b + 1, c_in ignored)
- `a`, `b`  in  WIDTH  operands, sampled on accepted start only
- `c_in`  in  1  carry-in for add, sampled with operands
- `ready`  out  1  block idle, will accept start
- `valid`  out  1  one-cycle pulse: result outputs are new
- `sum`  out  WIDTH  result, held until the next result
- `c_out`  out  1  carry out of MSB (for sub: 1 = no borrow)
- `overflow`  out  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `ready`=1. `start`=1 at an edge captures the operands into shift registers. B is inverted if `op_sub`. The carry register loads `op_sub ? 1 : c_in`, the chunk counter loads 0, and the FSM goes to BUSY.
- BUSY: each edge adds the low CHUNK bits of the A/B registers plus the carry register. The chunk result shifts into the MSB end of the result register, A/B shift right by CHUNK, the carry register takes the chunk carry-out, and the counter increments. At the edge where counter = N_CYC−1:
  - `sum` is loaded from the completed result.
  - `c_out` is loaded from the chunk carry-out.
  - `overflow` is loaded from the chunk's carry-into-MSB XOR its carry-out.
  - The FSM goes to DONE.
- DONE: `valid`=1 for exactly this cycle. The next edge returns to IDLE.
- `start` while `ready`=0 is ignored (not queued). Operand and `op_sub` changes after acceptance have no effect.
- Width rule: the result is modulo 2^WIDTH. `c_out` is bit WIDTH of the full sum.
- CHUNK = WIDTH (N_CYC=1): BUSY lasts one edge. Behaviour is otherwise identical.
- `sum`, `c_out` and `overflow` hold their last result through IDLE and BUSY.

## Timing
- Reset values: state=IDLE, `ready`=1, `valid`=0, `sum`=0, `c_out`=0, `overflow`=0. Internal registers and the counter are cleared.
- `ready` and `valid` are decoded directly from state registers, with no combinational path from inputs.
- Start accepted at edge k → BUSY edges k+1..k+N_CYC → `valid` high during the cycle after edge k+N_CYC → `ready` high again after edge k+N_CYC+1.
- Latency, accept to valid: N_CYC cycles. Minimum issue interval: N_CYC+2 cycles.
- Reset asserted mid-operation aborts immediately: outputs return to reset values and no `valid` pulse is produced. The first start after deassertion is accepted normally.
- `rst` and `start` at the same edge: reset wins.

## Structure
- Package `serial_adder_pkg`: state enum typedef `sa_state_t` {IDLE, BUSY, DONE}.
- Sub-module `chunk_adder #(CHUNK)`: CHUNK chained `full_adder` instances.
  - Inputs: `a`, `b`, `c_in`.
  - Outputs: `sum`, `c_out`, and `c_msb` (carry into the top cell) for overflow.
  - Purely combinational.
- Top level: FSM, counter, operand/result shift registers, carry register.

## Test plan
Benches use WIDTH=8, CHUNK=4 (N_CYC=2) unless noted. Each result is also checked against a+b+c_in / a−b.
- Reset: assert `rst` during BUSY → same cycle `ready`=1, `valid`=0, `sum`=0, `c_out`=0, `overflow`=0; no later `valid` pulse.
- Cross-chunk carry: add a=8'h0F, b=8'h01, c_in=0 → `valid` exactly 2 cycles after accept; `sum`=8'h10, `c_out`=0, `overflow`=0.
- Carry-out with c_in: add a=8'hFF, b=8'h01, c_in=1 → `sum`=8'h01, `c_out`=1, `overflow`=0.
- Overflow:
  - add 8'h7F+8'h01 → `sum`=8'h80, `overflow`=1.
  - sub 8'h80−8'h01 → `sum`=8'h7F, `overflow`=1, `c_out`=1.
  - sub 8'h05−8'h07 → `sum`=8'hFE, `c_out`=0, `overflow`=0.
- Handshake: `start` held high while busy, with a/b changed mid-op → single result from the first operands; `ready` low for N_CYC+1 cycles; next op accepted only from IDLE.
- Parameter sweep: (WIDTH,CHUNK) = (8,8), (8,1), (32,8) with 1000 random ops each → all match the reference model; latency = N_CYC.
